// File: rtl/sha3_rate_packer_if.sv
// Stream-side and block-side handshake bundle for the SHA3 rate packer.
// The packer takes the slave view; whatever feeds bytes and drains blocks takes the master view.
interface sha3_rate_packer_if #(
    parameter int HASH_BITS = 1088
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [HASH_BITS-1:0] blk;
    logic                 blk_valid;
    logic                 blk_last;
    logic                 blk_ready;
    logic                 busy;

    modport master (
        output in_data, in_valid, in_last, blk_ready,
        input  in_ready, blk, blk_valid, blk_last, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, blk_ready,
        output in_ready, blk, blk_valid, blk_last, busy
    );
endinterface

// File: rtl/sha3_rate_packer.sv
// Packs a byte stream into SHA3-256 rate blocks and applies the 0x06 ... 0x80
// pad to the final block; blocks are held registered until the hash core takes them.
module sha3_rate_packer #(
    parameter int         RATE_BYTES = 136,
    parameter int         HASH_BITS  = 1088,
    parameter logic [7:0] DSEP       = 8'h06,
    parameter logic [7:0] PAD_END    = 8'h80
) (
    input logic               clk,
    input logic               rst,
    sha3_rate_packer_if.slave bus
);
    localparam logic [7:0] LAST_IDX = 8'(RATE_BYTES - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [7:0]           idx_reg;
    logic                 in_ready_reg;
    logic                 blk_valid_reg;
    logic                 blk_last_reg;
    logic                 busy_reg;
    logic                 pend_pad_reg;
    logic [HASH_BITS-1:0] blk_reg;

    logic       accept;
    logic       xfer;
    logic       idx_full;
    logic       short_last;
    logic       pad_cycle;
    logic [7:0] idx_inc;

    // in_ready_reg is only ever set while in FILL, so it alone qualifies an accept.
    assign accept     = in_ready_reg & bus.in_valid;
    assign xfer       = blk_valid_reg & bus.blk_ready;
    assign idx_full   = (idx_reg == LAST_IDX);
    assign idx_inc    = idx_reg + 8'd1;
    assign short_last = accept & bus.in_last & ~idx_full;
    assign pad_cycle  = (state_reg == PAD);

    // One register lane per byte: each lane decodes its own write from idx and the FSM state.
    generate
        for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_lane
            localparam logic [7:0] LANE       = 8'(gi);
            localparam bit         LANE_FIRST = (gi == 0);
            localparam bit         LANE_FINAL = (gi == RATE_BYTES - 1);

            logic [7:0] byte_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byte_reg <= 8'h00;
                end else if (xfer) begin
                    byte_reg <= 8'h00;
                end else if (accept && (idx_reg == LANE)) begin
                    byte_reg <= bus.in_data;
                end else if (short_last && (idx_inc == LANE)) begin
                    byte_reg <= LANE_FINAL ? (DSEP | PAD_END) : DSEP;
                end else if (short_last && LANE_FINAL) begin
                    byte_reg <= byte_reg | PAD_END;
                end else if (pad_cycle && LANE_FIRST) begin
                    byte_reg <= DSEP;
                end else if (pad_cycle && LANE_FINAL) begin
                    byte_reg <= PAD_END;
                end
            end

            assign blk_reg[8*gi +: 8] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= FILL;
            idx_reg       <= 8'd0;
            in_ready_reg  <= 1'b0;
            blk_valid_reg <= 1'b0;
            blk_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            pend_pad_reg  <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        busy_reg <= 1'b1;
                        if (idx_full) begin
                            // Full block; a last byte here still owes a padding-only block.
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            blk_valid_reg <= 1'b1;
                            blk_last_reg  <= 1'b0;
                            pend_pad_reg  <= bus.in_last;
                        end else if (bus.in_last) begin
                            state_reg     <= HOLD;
                            in_ready_reg  <= 1'b0;
                            blk_valid_reg <= 1'b1;
                            blk_last_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_inc;
                        end
                    end
                end

                HOLD: begin
                    if (bus.blk_ready) begin
                        blk_valid_reg <= 1'b0;
                        blk_last_reg  <= 1'b0;
                        idx_reg       <= 8'd0;
                        if (pend_pad_reg) begin
                            state_reg <= PAD;
                        end else begin
                            state_reg    <= FILL;
                            in_ready_reg <= 1'b1;
                            if (blk_last_reg) begin
                                busy_reg <= 1'b0;
                            end
                        end
                    end
                end

                PAD: begin
                    state_reg     <= HOLD;
                    blk_valid_reg <= 1'b1;
                    blk_last_reg  <= 1'b1;
                    pend_pad_reg  <= 1'b0;
                end

                default: begin
                    state_reg     <= FILL;
                    in_ready_reg  <= 1'b0;
                    blk_valid_reg <= 1'b0;
                    blk_last_reg  <= 1'b0;
                    pend_pad_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.blk       = blk_reg;
    assign bus.blk_valid = blk_valid_reg;
    assign bus.blk_last  = blk_last_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_sha3_rate_packer.sv
// Randomized scoreboard bench for sha3_rate_packer: expected blocks come from a
// byte-level SHA3 pad10*1 model; a negedge monitor pops and compares on every transfer.
module tb_sha3_rate_packer;
    localparam int RATE  = 136;
    localparam int HB    = 1088;
    localparam int LIMIT = 3000;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [HB-1:0] data;
        bit            last;
        bit            pad_only;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   ready_mode = 0;
    int   gap_mode = 0;
    int   cyc = 0;
    int   blk_no = 0;
    int   stall = 0;

    sha3_rate_packer_if #(.HASH_BITS(HB)) bus();

    sha3_rate_packer #(
        .RATE_BYTES(RATE),
        .HASH_BITS (HB),
        .DSEP      (8'h06),
        .PAD_END   (8'h80)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int first_diff(input logic [HB-1:0] a, input logic [HB-1:0] b);
        for (int i = 0; i < RATE; i++) begin
            if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        end
        return -1;
    endfunction

    function automatic void check_zero(input string name);
        int d;
        n_cmp++;
        d = first_diff(bus.blk, '0);
        if (d >= 0) begin
            n_bad++;
            $display("FAIL %s: byte %0d got %02h expected 00", name, d, bus.blk[8*d +: 8]);
        end
    endfunction

    // SHA3 pad10*1 on bytes: append 0x06, zero-fill to a rate multiple, OR 0x80 into the last byte.
    task automatic model_push(input bq_t msg);
        bq_t  p;
        int   nblk;
        exp_t e;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % RATE != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / RATE;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int i = 0; i < RATE; i++) e.data[8*i +: 8] = p[b*RATE + i];
            e.last     = (b == nblk - 1);
            e.pad_only = e.last && (msg.size() % RATE == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = (gap_mode == 1) ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_msg(input bq_t msg, input int abort_after);
        int n;
        int w;
        bit need_lat;
        n = msg.size();
        if (abort_after == 0) model_push(msg);
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            else if (gap_mode == 2) idle($urandom_range(0, 3));
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            bus.in_last  = (i == n - 1);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!bus.in_ready && w < LIMIT);
            if (!bus.in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: byte %0d in_ready got 0 expected 1", i);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
            if (abort_after > 0 && i + 1 == abort_after) begin
                rst = 1'b0;
                #1;
                check("abort_blk_valid", bus.blk_valid, 0);
                check("abort_blk_last", bus.blk_last, 0);
                check("abort_busy", bus.busy, 0);
                check("abort_in_ready", bus.in_ready, 0);
                check_zero("abort_blk_zero");
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                $display("abort after %0d bytes", abort_after);
                return;
            end
            need_lat = (i == n - 1) || ((i + 1) % RATE == 0);
            if (i == 0 || need_lat) begin
                @(negedge clk);
                if (i == 0) check("busy_set", bus.busy, 1);
                if (need_lat) check("blk_valid_latency", bus.blk_valid, 1);
                @(posedge clk); #1;
            end
        end
        w = 0;
        while (exp_q.size() != 0 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d blocks outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("busy_clear", bus.busy, 0);
        @(posedge clk); #1;
        $display("msg len=%0d done", n);
    endtask

    // Block-side ready driver: 0 always ready, 1 random, 2 stall 10 cycles per block.
    initial begin
        bus.blk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.blk_ready = 1'b1;
                1: bus.blk_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (!bus.blk_valid) begin
                        stall = 0;
                        bus.blk_ready = 1'b0;
                    end else if (stall < 10) begin
                        stall++;
                        bus.blk_ready = 1'b0;
                    end else begin
                        bus.blk_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: every transfer pops the scoreboard; stalls must hold blk bit-stable.
    initial begin
        logic [HB-1:0] prev_blk;
        logic          prev_last;
        bit            prev_hold;
        int            pad_due;
        exp_t          e;
        int            d;
        prev_blk  = '0;
        prev_last = 1'b0;
        prev_hold = 1'b0;
        pad_due   = -10;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_hold = 1'b0;
                pad_due   = -10;
            end else begin
                if (cyc == pad_due - 1) begin
                    check("pad_gap_valid", bus.blk_valid, 0);
                    check("pad_gap_in_ready", bus.in_ready, 0);
                end
                if (cyc == pad_due) check("pad_latency", bus.blk_valid, 1);
                if (prev_hold) begin
                    check("stall_valid", bus.blk_valid, 1);
                    check("stall_last", bus.blk_last, prev_last);
                    n_cmp++;
                    d = first_diff(bus.blk, prev_blk);
                    if (d >= 0) begin
                        n_bad++;
                        $display("FAIL stall_stable: byte %0d got %02h expected %02h", d, bus.blk[8*d +: 8], prev_blk[8*d +: 8]);
                    end
                end
                if (bus.blk_valid) check("in_ready_in_hold", bus.in_ready, 0);
                if (bus.blk_valid && bus.blk_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_blk: got block with last=%0b expected none", bus.blk_last);
                    end else begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        d = first_diff(bus.blk, e.data);
                        if (d >= 0) begin
                            n_bad++;
                            $display("FAIL blk_data: blk %0d byte %0d got %02h expected %02h", blk_no, d, bus.blk[8*d +: 8], e.data[8*d +: 8]);
                        end
                        check("blk_last", bus.blk_last, e.last);
                        $display("blk %0d: last=%0b b0=%02h b1=%02h b135=%02h", blk_no, bus.blk_last,
                                 bus.blk[7:0], bus.blk[15:8], bus.blk[HB-1 -: 8]);
                        blk_no++;
                        if (!e.last && exp_q.size() > 0 && exp_q[0].pad_only) pad_due = cyc + 2;
                    end
                end
                prev_hold = bus.blk_valid && !bus.blk_ready;
                prev_blk  = bus.blk;
                prev_last = bus.blk_last;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t m;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_blk_valid", bus.blk_valid, 0);
        check("reset_blk_last", bus.blk_last, 0);
        check("reset_busy", bus.busy, 0);
        check_zero("reset_blk_zero");
        rst = 1'b1;
        @(posedge clk); #1;

        ready_mode = 0;
        gap_mode   = 0;
        m.delete();
        m.push_back(8'hAB);
        send_msg(m, 0);

        m.delete();
        for (int i = 0; i < 135; i++) m.push_back(8'(i));
        send_msg(m, 0);

        m.delete();
        for (int i = 0; i < 136; i++) m.push_back(8'($urandom));
        send_msg(m, 0);

        ready_mode = 2;
        m.delete();
        for (int i = 0; i < 300; i++) m.push_back(8'(i));
        send_msg(m, 0);

        ready_mode = 0;
        m.delete();
        for (int i = 0; i < 80; i++) m.push_back(8'($urandom_range(1, 255)));
        send_msg(m, 50);
        m.delete();
        m.push_back(8'h11);
        send_msg(m, 0);

        gap_mode = 1;
        ready_mode = 1;
        m.delete();
        for (int i = 0; i < 150; i++) m.push_back(8'($urandom));
        send_msg(m, 0);

        for (int k = 0; k < 20; k++) begin
            gap_mode   = $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 2);
            m.delete();
            for (int i = 0; i < int'($urandom_range(1, 400)); i++) m.push_back(8'($urandom));
            send_msg(m, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
